// File: rtl/clk_div_gen.sv
// -----------------------------------------------------------------------------
// clk_div_gen : multi-channel programmable clock-enable / square-wave generator
//
// Every channel divides clkin1 by a programmable period (div) and produces a
// registered square wave that is high for 'high' cycles of every period, plus
// a one-cycle clk_en pulse at the start of each period. All logic runs in the
// clkin1 domain; nothing here creates a new clock.
//
// Parameters
//   NUM_CH  : number of independent channels (1..8)
//   CNT_W   : counter / configuration width
//   DEF_DIV : period loaded at reset (high time = DEF_DIV/2)
//
// Ports
//   clkin1     in   clock
//   pll_rst    in   asynchronous active-low reset
//   pll_lock   in   global run enable; all counters held at start while low
//   ch_en      in   per-channel run enable
//   cfg_valid  in   configuration write request
//   cfg_ready  out  write to cfg_ch can be accepted this cycle
//   cfg_ch     in   target channel of the write
//   cfg_div    in   new period in clkin1 cycles (clamped to >= 2)
//   cfg_high   in   new high time (clamped to 1..div-1)
//   cfg_phase  in   start offset, clamped to div-1 (CLK_DIV_PHASE_EN only)
//   clk_out    out  registered divided square waves
//   clk_en     out  one-cycle pulse in the cycle clk_out rises
//
// Optional feature: define CLK_DIV_PHASE_EN to add cfg_phase. Each channel then
// starts counting from its phase instead of 0 whenever it (re)starts.
//
// Config handshake: a write transfers on a rising clkin1 edge where
// cfg_valid && cfg_ready. cfg_ready is a combinational function of cfg_ch and
// the target's pending flag only (never of cfg_valid), is low for an
// out-of-range cfg_ch, and a requester holds cfg_valid and its payload stable
// until the transfer happens.
// -----------------------------------------------------------------------------
module clk_div_gen #(
  parameter int NUM_CH  = 4,
  parameter int CNT_W   = 16,
  parameter int DEF_DIV = 2500
) (
  input  logic              clkin1,
  input  logic              pll_rst,
  input  logic              pll_lock,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [2:0]        cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  input  logic [CNT_W-1:0]  cfg_high,
`ifdef CLK_DIV_PHASE_EN
  input  logic [CNT_W-1:0]  cfg_phase,
`endif
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] clk_en
);

  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO      = CNT_W'(2);
  localparam logic [CNT_W-1:0] RST_DIV  = CNT_W'(DEF_DIV);
  localparam logic [CNT_W-1:0] RST_HIGH = CNT_W'(DEF_DIV / 2);

  // ---------------------------------------------------------------------------
  // Write payload legalisation, shared by all channels. high is clamped
  // against the already-clamped div so the pair is always consistent.
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] div_c;
  logic [CNT_W-1:0] high_c;
`ifdef CLK_DIV_PHASE_EN
  logic [CNT_W-1:0] phase_c;
`endif

  always_comb begin
    div_c  = (cfg_div < TWO) ? TWO : cfg_div;
    high_c = (cfg_high == '0) ? ONE : cfg_high;
    if (high_c >= div_c) high_c = div_c - ONE;
`ifdef CLK_DIV_PHASE_EN
    phase_c = (cfg_phase >= div_c) ? (div_c - ONE) : cfg_phase;
`endif
  end

  // ---------------------------------------------------------------------------
  // Handshake: ready reflects the addressed channel's pending flag. The loop
  // naturally leaves ready low for indices beyond NUM_CH-1.
  // ---------------------------------------------------------------------------
  logic [NUM_CH-1:0] pend_vec;
  logic              wr_acc;

  always_comb begin
    cfg_ready = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg_ch == 3'(i)) cfg_ready = ~pend_vec[i];
    end
  end

  assign wr_acc = cfg_valid && cfg_ready;

  // ---------------------------------------------------------------------------
  // Per-channel divider
  // ---------------------------------------------------------------------------
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [CNT_W-1:0] div_q,   div_d;
    logic [CNT_W-1:0] high_q,  high_d;
    logic [CNT_W-1:0] sdiv_q,  sdiv_d;
    logic [CNT_W-1:0] shigh_q, shigh_d;
    logic             pend_q,  pend_d;
    logic             out_q,   out_d;
    logic             en_q,    en_d;
    logic [CNT_W-1:0] start_cnt;
    logic             run;
    logic             last;
    logic             apply;
    logic             wr_sel;
`ifdef CLK_DIV_PHASE_EN
    logic [CNT_W-1:0] phase_q,  phase_d;
    logic [CNT_W-1:0] sphase_q, sphase_d;
`endif

    assign run    = pll_lock && ch_en[g];
    assign last   = (cnt_q == div_q - ONE);
    // A running channel swaps config only on its wrap so every emitted
    // period is whole; a stopped channel has no period to protect.
    assign apply  = pend_q && (run ? last : 1'b1);
    // wr_acc implies pend_q==0 for this channel, so apply and wr_sel are
    // never both true for the same channel.
    assign wr_sel = wr_acc && (cfg_ch == 3'(g));

`ifdef CLK_DIV_PHASE_EN
    // Restart offset follows whatever config becomes active on this edge.
    assign start_cnt = apply ? sphase_q : phase_q;
`else
    assign start_cnt = '0;
`endif

    always_comb begin
      cnt_d   = cnt_q;
      div_d   = div_q;
      high_d  = high_q;
      sdiv_d  = sdiv_q;
      shigh_d = shigh_q;
      pend_d  = pend_q;
      out_d   = 1'b0;
      en_d    = 1'b0;
`ifdef CLK_DIV_PHASE_EN
      phase_d  = phase_q;
      sphase_d = sphase_q;
`endif

      if (apply) begin
        div_d   = sdiv_q;
        high_d  = shigh_q;
        pend_d  = 1'b0;
`ifdef CLK_DIV_PHASE_EN
        phase_d = sphase_q;
`endif
      end

      if (wr_sel) begin
        sdiv_d   = div_c;
        shigh_d  = high_c;
        pend_d   = 1'b1;
`ifdef CLK_DIV_PHASE_EN
        sphase_d = phase_c;
`endif
      end

      if (run) begin
        cnt_d = last ? '0 : (cnt_q + ONE);
        // Outputs are decoded from the current count, so they lag it by one.
        out_d = (cnt_q < high_q);
        en_d  = (cnt_q == '0);
      end else begin
        cnt_d = start_cnt;
      end
    end

    always_ff @(posedge clkin1 or negedge pll_rst) begin
      if (!pll_rst) begin
        cnt_q    <= '0;
        div_q    <= RST_DIV;
        high_q   <= RST_HIGH;
        sdiv_q   <= RST_DIV;
        shigh_q  <= RST_HIGH;
        pend_q   <= 1'b0;
        out_q    <= 1'b0;
        en_q     <= 1'b0;
`ifdef CLK_DIV_PHASE_EN
        phase_q  <= '0;
        sphase_q <= '0;
`endif
      end else begin
        cnt_q    <= cnt_d;
        div_q    <= div_d;
        high_q   <= high_d;
        sdiv_q   <= sdiv_d;
        shigh_q  <= shigh_d;
        pend_q   <= pend_d;
        out_q    <= out_d;
        en_q     <= en_d;
`ifdef CLK_DIV_PHASE_EN
        phase_q  <= phase_d;
        sphase_q <= sphase_d;
`endif
      end
    end

    assign pend_vec[g] = pend_q;
    assign clk_out[g]  = out_q;
    assign clk_en[g]   = en_q;
  end

endmodule
